pipe_bundle_reg: RTL and testbench
==================================

Name: pipe_bundle_reg

Overview:
Parametrised N-lane pipeline register between two multi-issue stages, e.g. decode→execute. It is the generalisation of the fixed dual-lane stage register.
- Holds up to LANES instructions and lets the downstream stage consume a partial bundle (oldest first).
- Compacts survivors toward lane 0.
- Supports a full exception flush and a partial branch kill of younger lanes.
- Generates its own allowin instead of taking it as an input.

Parameters:
LANES, 2, number of instruction lanes (2..8).
DW, 64, data bits per lane.
LW, $clog2(LANES), lane-index width (minimum 1).
CW, $clog2(LANES+1), count width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
pre_valid_i  in  LANES  per-lane valid from upstream stage
pre_bus_i  in  LANES*DW  upstream lane data, lane i at [i*DW +: DW]
now_allowin_o  out  1  stage accepts a new bundle this cycle (combinational)
now_valid_o  out  LANES  per-lane valid of held entries, always thermometer from lane 0
now_bus_o  out  LANES*DW  held lane data
occupancy_o  out  CW  number of valid held entries
next_take_i  in  CW  number of oldest entries downstream consumes this cycle
excep_flush_i  in  1  kill all held entries, block capture
kill_valid_i  in  1  branch kill request
kill_lane_i  in  LW  lanes with index >= kill_lane_i are killed

Behaviour:
- Reset (async, rst=1):
  - occupancy=0, now_valid_o=0, now_bus_o=0.
  - Outputs hold these values until the first rising edge after rst deasserts.
- Per-cycle combinational terms:
  - kept = kill_valid_i ? min(occ, kill_lane_i) : occ
  - take_eff = min(next_take_i, kept), saturating
  - remain = kept - take_eff
- now_allowin_o = (remain == 0) && !excep_flush_i && !kill_valid_i. It may depend combinationally on next_take_i; there is no path from pre_* to allowin.
- Capture:
  - Condition: now_allowin_o && |pre_valid_i.
  - Valid lanes of pre_bus_i are compacted in ascending lane order into lanes 0..k-1, where k = popcount(pre_valid_i).
  - occupancy becomes k. Visible next cycle (latency 1).
- No capture, no flush:
  - Entries take_eff..kept-1 shift down by take_eff lanes.
  - occupancy becomes remain.
  - Vacated lanes' data is unchanged (don't-care). Their valid bits are 0.
- Priority, highest first:
  1. excep_flush_i: occupancy:=0, no capture. Data registers are not written.
  2. kill_valid_i: kill, then take, then shift. No capture that cycle.
  3. Normal take/shift/capture.
- Taking everything (remain==0) with |pre_valid_i in the same cycle: capture occurs; this is back-to-back flow with no bubble.
- next_take_i > occupancy: clamped, never underflows. next_take_i with occ=0 has no effect.
- kill_lane_i=0 kills all entries. kill_lane_i >= occ kills nothing.
- pre_valid_i==0 while allowin: stage becomes or stays empty.
- Data enable:
  - Only lanes written by capture or shift toggle.
  - When the stage is stalled (take_eff=0, no kill), data registers and valid bits hold.
- Invariant, asserted in the bench: now_valid_o == (1<<occupancy)-1.

Test Plan:
- Reset mid-operation: occ=2, assert rst asynchronously between edges → now_valid_o=0, occupancy_o=0, now_bus_o=0 immediately, before the next edge.
- LANES=4, pre_valid_i=4'b1010, lanes 1/3 data 0xA/0xB, stage empty → next cycle now_valid_o=4'b0011, lane0=0xA, lane1=0xB, occupancy_o=2.
- Partial take: occ=4 with data D0..D3, next_take_i=1 → allowin=0. Next cycle lanes=D1,D2,D3, valid=4'b0111. Then next_take_i=3 with pre_valid_i=4'b0001 → captured same cycle, occupancy_o=1.
- Kill+take: occ=4, kill_valid_i=1, kill_lane_i=3, next_take_i=1 → next cycle valid=4'b0011 holding D1,D2. pre_valid_i ignored that cycle.
- Flush priority: occ=3, excep_flush_i=1, pre_valid_i=4'b1111, next_take_i=0 → next cycle occupancy_o=0, allowin was 0 during the flush cycle.
- Stall and clamp: occ=2, next_take_i=0 for 5 cycles → data and valid stable, allowin=0. Then next_take_i=4 → occupancy_o=0 with no underflow, and allowin=1 in that cycle.

Source files
------------

// File: rtl/pipe_bundle_reg.sv
// N-lane pipeline register between multi-issue stages.
// Holds a compacted bundle, drains it oldest-first, and handles flush/kill.
module pipe_bundle_reg #(
    parameter int LANES = 2,
    parameter int DW    = 64,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    pre_valid_i,
    input  logic [LANES*DW-1:0] pre_bus_i,
    output logic                now_allowin_o,
    output logic [LANES-1:0]    now_valid_o,
    output logic [LANES*DW-1:0] now_bus_o,
    output logic [CW-1:0]       occupancy_o,
    input  logic [CW-1:0]       next_take_i,
    input  logic                excep_flush_i,
    input  logic                kill_valid_i,
    input  logic [LW-1:0]       kill_lane_i
);

    logic [LANES-1:0][DW-1:0] data_q;
    logic [LANES-1:0][DW-1:0] data_d;
    logic [LANES-1:0][DW-1:0] shift_d;
    logic [LANES-1:0][DW-1:0] cap_d;
    logic [LANES-1:0]         we;
    logic [CW-1:0]            occ_q;
    logic [CW-1:0]            occ_d;
    logic [CW-1:0]            kill_ext;
    logic [CW-1:0]            kept;
    logic [CW-1:0]            take_eff;
    logic [CW-1:0]            remain;
    logic [CW-1:0]            cap_cnt;
    logic [CW-1:0]            rank [LANES];
    logic                     capture;

    assign kill_ext = CW'(kill_lane_i);

    always_comb begin
        kept = occ_q;
        if (kill_valid_i && (kill_ext < occ_q)) begin
            kept = kill_ext;
        end
        take_eff = (next_take_i < kept) ? next_take_i : kept;
        remain   = kept - take_eff;
    end

    assign now_allowin_o = (remain == '0) && !excep_flush_i && !kill_valid_i;
    assign capture       = now_allowin_o && (|pre_valid_i);

    // rank[i] = number of valid upstream lanes below lane i
    always_comb begin
        cap_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            rank[i] = cap_cnt;
            cap_cnt = cap_cnt + CW'(pre_valid_i[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            cap_d[j] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (pre_valid_i[i] && (rank[i] == CW'(j))) begin
                    cap_d[j] = pre_bus_i[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            shift_d[j] = data_q[j];
            for (int s = 0; s < LANES; s++) begin
                if ((s >= j) && (CW'(s - j) == take_eff)) begin
                    shift_d[j] = data_q[s];
                end
            end
        end
    end

    // Only lanes that actually receive new content are enabled
    always_comb begin
        occ_d  = occ_q;
        we     = '0;
        data_d = data_q;
        if (excep_flush_i) begin
            occ_d = '0;
        end else if (capture) begin
            occ_d = cap_cnt;
            for (int j = 0; j < LANES; j++) begin
                if (CW'(j) < cap_cnt) begin
                    we[j]     = 1'b1;
                    data_d[j] = cap_d[j];
                end
            end
        end else begin
            occ_d = remain;
            if (take_eff != '0) begin
                for (int j = 0; j < LANES; j++) begin
                    if (CW'(j) < remain) begin
                        we[j]     = 1'b1;
                        data_d[j] = shift_d[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= '0;
            data_q <= '0;
        end else begin
            occ_q <= occ_d;
            for (int j = 0; j < LANES; j++) begin
                if (we[j]) begin
                    data_q[j] <= data_d[j];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            now_valid_o[j] = (CW'(j) < occ_q);
        end
    end

    assign now_bus_o   = data_q;
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_bundle_reg.sv
// Bench for pipe_bundle_reg with LANES=4: directed plan plus random traffic
// checked against a queue-based model of the held bundle.
module tb_pipe_bundle_reg;

    localparam int LANES = 4;
    localparam int DW    = 32;

    logic                     clk;
    logic                     rst;
    logic [LANES-1:0]         pre_valid;
    logic [LANES*DW-1:0]      pre_bus;
    logic                     now_allowin;
    logic [LANES-1:0]         now_valid;
    logic [LANES*DW-1:0]      now_bus;
    logic [2:0]               occupancy;
    logic [2:0]               next_take;
    logic                     excep_flush;
    logic                     kill_valid;
    logic [1:0]               kill_lane;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];

    pipe_bundle_reg #(.LANES(LANES), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pre_valid_i   (pre_valid),
        .pre_bus_i     (pre_bus),
        .now_allowin_o (now_allowin),
        .now_valid_o   (now_valid),
        .now_bus_o     (now_bus),
        .occupancy_o   (occupancy),
        .next_take_i   (next_take),
        .excep_flush_i (excep_flush),
        .kill_valid_i  (kill_valid),
        .kill_lane_i   (kill_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [LANES-1:0] ev;
        ev = LANES'((1 << mq.size()) - 1);
        chk({tag, "_occ"}, 128'(occupancy), 128'(mq.size()));
        chk({tag, "_valid"}, 128'(now_valid), 128'(ev));
        for (int i = 0; i < mq.size(); i++) begin
            chk($sformatf("%s_lane%0d", tag, i),
                128'(now_bus[i*DW +: DW]), 128'(mq[i]));
        end
    endtask

    // One clock: drive inputs, check allowin, clock, update model, check state
    task automatic step(input string tag, input logic [LANES-1:0] pv,
                        input logic [LANES*DW-1:0] bus, input int nt,
                        input bit fl, input bit kv, input int kl);
        int  occ;
        int  kept;
        int  take;
        int  rem;
        bit  allow;
        pre_valid   = pv;
        pre_bus     = bus;
        next_take   = 3'(nt);
        excep_flush = fl;
        kill_valid  = kv;
        kill_lane   = 2'(kl);
        #1;
        occ   = mq.size();
        kept  = (kv && kl < occ) ? kl : occ;
        take  = (nt < kept) ? nt : kept;
        rem   = kept - take;
        allow = (rem == 0) && !fl && !kv;
        chk({tag, "_allowin"}, 128'(now_allowin), 128'(allow));
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else if (allow && pv != '0) begin
            mq.delete();
            for (int i = 0; i < LANES; i++)
                if (pv[i]) mq.push_back(bus[i*DW +: DW]);
        end else begin
            while (mq.size() > kept) void'(mq.pop_back());
            repeat (take) void'(mq.pop_front());
        end
        #1;
        check_state(tag);
    endtask

    function automatic logic [LANES*DW-1:0] mk(input logic [DW-1:0] d0,
        input logic [DW-1:0] d1, input logic [DW-1:0] d2,
        input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        logic [LANES*DW-1:0] rb;
        logic [LANES*DW-1:0] frozen;
        rst = 1'b1;
        pre_valid = '0;
        pre_bus = '0;
        next_take = '0;
        excep_flush = 1'b0;
        kill_valid = 1'b0;
        kill_lane = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_valid", 128'(now_valid), 128'(0));
        chk("rst_bus", 128'(now_bus), 128'(0));

        step("cmp", 4'b1010, mk(32'h1, 32'hA, 32'h2, 32'hB), 0, 0, 0, 0);
        chk("cmp_v", 128'(now_valid), 128'(4'b0011));
        chk("cmp_l0", 128'(now_bus[31:0]), 128'(32'hA));
        chk("cmp_l1", 128'(now_bus[63:32]), 128'(32'hB));
        chk("cmp_occ", 128'(occupancy), 128'(2));

        pre_valid = '0;
        rst = 1'b1;
        #2;
        chk("arst_occ", 128'(occupancy), 128'(0));
        chk("arst_valid", 128'(now_valid), 128'(0));
        chk("arst_bus", 128'(now_bus), 128'(0));
        rst = 1'b0;
        mq.delete();
        #1;

        step("fill", 4'b1111, mk(32'hD0, 32'hD1, 32'hD2, 32'hD3), 0, 0, 0, 0);
        step("take1", 4'b1111, mk(1, 2, 3, 4), 1, 0, 0, 0);
        chk("take1_v", 128'(now_valid), 128'(4'b0111));
        chk("take1_l0", 128'(now_bus[31:0]), 128'(32'hD1));
        step("take3", 4'b0001, mk(32'hE0, 0, 0, 0), 3, 0, 0, 0);
        chk("take3_occ", 128'(occupancy), 128'(1));
        chk("take3_l0", 128'(now_bus[31:0]), 128'(32'hE0));

        step("refill", 4'b1111, mk(32'hD0, 32'hD1, 32'hD2, 32'hD3), 1, 0, 0, 0);
        step("kill", 4'b1111, mk(5, 6, 7, 8), 1, 0, 1, 3);
        chk("kill_v", 128'(now_valid), 128'(4'b0011));
        chk("kill_l1", 128'(now_bus[63:32]), 128'(32'hD2));

        step("fill3", 4'b0111, mk(32'hF0, 32'hF1, 32'hF2, 0), 2, 0, 0, 0);
        step("flush", 4'b1111, mk(9, 9, 9, 9), 0, 1, 0, 0);
        chk("flush_occ", 128'(occupancy), 128'(0));

        step("fill2", 4'b0011, mk(32'hC0, 32'hC1, 0, 0), 0, 0, 0, 0);
        frozen = now_bus;
        for (int c = 0; c < 5; c++) begin
            step($sformatf("stall%0d", c), 4'b1111, mk(1, 1, 1, 1), 0, 0, 0, 0);
            chk($sformatf("stall%0d_bus", c), 128'(now_bus), 128'(frozen));
        end
        step("clamp", 4'b0000, '0, 4, 0, 0, 0);
        chk("clamp_occ", 128'(occupancy), 128'(0));

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < LANES; i++) rb[i*DW +: DW] = $urandom;
            step($sformatf("rnd%0d", c), LANES'($urandom), rb,
                 $urandom_range(0, 7), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 6) == 0), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
